// File: rtl/clock_pkg.sv
// Shared types and constants for the SPI time/date receiver.
// Frame layout: header, hour, minute, second, month, day, year (MSB first).
package clock_pkg;

  localparam int FRAME_BITS = 40;
  localparam logic [7:0] HEADER = 8'hA5;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MON_W  = 4;
  localparam int DAY_W  = 5;
  localparam int YEAR_W = 6;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;
  localparam int MAX_MON  = 12;
  localparam int MAX_DAY  = 31;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [MON_W-1:0]  month;
    logic [DAY_W-1:0]  day;
    logic [YEAR_W-1:0] year;
  } time_fields_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } spi_state_t;

  localparam time_fields_t RESET_FIELDS = '{
    hour:   '0,
    minute: '0,
    second: '0,
    month:  MON_W'(1),
    day:    DAY_W'(1),
    year:   '0
  };

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer with rise/fall pulses derived from flopped values.
// Ports: clk, reset, d (async in), q (synced), rise, fall (1-cycle pulses).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];
  // Pulses decode two flops directly so the FSM can act on the same
  // cycle the synced level changes; this keeps commit latency at STAGES+1.
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_time_receiver.sv
// Oversampling SPI receiver for time/date frames; commits validated frames atomically.
// Ports: clk, reset, sclk/sdi/ss_b (async SPI), time fields, time_valid, frame_stb, frame_err.
module spi_time_receiver
  import clock_pkg::*;
#(
  parameter int         CLK_SYNC_STAGES = 2,
  parameter int         FRAME_BITS      = clock_pkg::FRAME_BITS,
  parameter logic [7:0] HEADER          = clock_pkg::HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sdi,
  input  logic              ss_b,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [MON_W-1:0]  month,
  output logic [DAY_W-1:0]  day,
  output logic [YEAR_W-1:0] year,
  output logic              time_valid,
  output logic              frame_stb,
  output logic              frame_err
);

  logic sclk_rise;
  logic sclk_q_unused;
  logic sclk_fall_unused;
  logic sdi_s;
  logic sdi_rise_unused;
  logic sdi_fall_unused;
  logic ss_rise;
  logic ss_fall;
  logic ss_q_unused;

  sync_edge #(.STAGES(CLK_SYNC_STAGES)) u_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .q    (sclk_q_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  sync_edge #(.STAGES(CLK_SYNC_STAGES)) u_sdi (
    .clk  (clk),
    .reset(reset),
    .d    (sdi),
    .q    (sdi_s),
    .rise (sdi_rise_unused),
    .fall (sdi_fall_unused)
  );

  // ss_b sync flops reset low: a reset taken mid-frame then sees no
  // fall until the PIC releases and re-asserts select.
  sync_edge #(.STAGES(CLK_SYNC_STAGES)) u_ss (
    .clk  (clk),
    .reset(reset),
    .d    (ss_b),
    .q    (ss_q_unused),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_state_t              state;
  logic [5:0]              cnt;
  logic [FRAME_BITS-1:0]   sr;
  time_fields_t            fields;
  time_fields_t            rx;
  logic [7:0]              rx_hdr;
  logic                    frame_ok;

  assign rx_hdr = sr[39:32];
  assign rx     = sr[31:0];

  always_comb begin
    frame_ok = (cnt == 6'(FRAME_BITS))
             && (rx_hdr == HEADER)
             && (rx.hour <= HOUR_W'(MAX_HOUR))
             && (rx.minute <= MIN_W'(MAX_MIN))
             && (rx.second <= SEC_W'(MAX_SEC))
             && (rx.month != '0)
             && (rx.month <= MON_W'(MAX_MON))
             && (rx.day != '0)
             && ({1'b0, rx.day} <= 6'(MAX_DAY));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      fields     <= RESET_FIELDS;
      time_valid <= 1'b0;
      frame_stb  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            cnt   <= '0;
            sr    <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            if (frame_ok) begin
              fields     <= rx;
              time_valid <= 1'b1;
              frame_stb  <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
          end else if (sclk_rise) begin
            sr  <= {sr[FRAME_BITS-2:0], sdi_s};
            cnt <= cnt + 6'd1;
            // Bit FRAME_BITS+1 is an overrun; count parks there.
            if (cnt == 6'(FRAME_BITS)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hour   = fields.hour;
  assign minute = fields.minute;
  assign second = fields.second;
  assign month  = fields.month;
  assign day    = fields.day;
  assign year   = fields.year;

endmodule

// File: tb/tb_spi_time_receiver.sv
// Scoreboard bench for spi_time_receiver: directed frames, queued expectations.
// A negedge monitor pops and checks each frame_stb/frame_err pulse.
`timescale 1ns/1ps
module tb_spi_time_receiver;

  localparam int STAGES = 2;
  localparam int HALF   = 10;
  localparam logic [31:0] RST_F = {5'd0, 6'd0, 6'd0, 4'd1, 5'd1, 6'd0};

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       sdi;
  logic       ss_b;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [3:0] month;
  logic [4:0] day;
  logic [5:0] year;
  logic       time_valid;
  logic       frame_stb;
  logic       frame_err;

  spi_time_receiver #(.CLK_SYNC_STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sdi       (sdi),
    .ss_b      (ss_b),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .month     (month),
    .day       (day),
    .year      (year),
    .time_valid(time_valid),
    .frame_stb (frame_stb),
    .frame_err (frame_err)
  );

  always #12.5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        err;
    logic [31:0] f;
    logic        tv;
    longint      c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cur_f  = RST_F;
  logic        cur_tv = 1'b0;
  int          pass   = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [39:0] mk(input logic [7:0] h8, input int hr,
    input int mi, input int se, input int mo, input int dy, input int yr);
    return {h8, hr[4:0], mi[5:0], se[5:0], mo[3:0], dy[4:0], yr[5:0]};
  endfunction

  function automatic logic [31:0] outs();
    return {hour, minute, second, month, day, year};
  endfunction

  task automatic shift_bits(input logic [63:0] bits, input int hi,
                            input int lo);
    for (int i = hi; i >= lo; i--) begin
      sdi = bits[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Called at a negedge; ok is the hand-derived accept verdict.
  task automatic send(input logic [63:0] bits, input int n, input bit ok,
                      input int gap);
    exp_t e;
    ss_b = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(bits, n - 1, 0);
    repeat (4) @(negedge clk);
    ss_b = 1'b1;
    if (ok) begin
      cur_f  = bits[31:0];
      cur_tv = 1'b1;
    end
    e.err = !ok;
    e.f   = cur_f;
    e.tv  = cur_tv;
    e.c   = cyc;
    q.push_back(e);
    repeat (gap) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (frame_stb || frame_err)) begin
        check("stb_err_exclusive", {frame_stb, frame_err} == 2'b11, 0);
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse: stb=%0b err=%0b with empty queue",
                   frame_stb, frame_err);
        end else begin
          e = q.pop_front();
          check("pulse_kind", {frame_stb, frame_err}, {!e.err, e.err});
          check("fields", outs(), e.f);
          check("time_valid", time_valid, e.tv);
          check("latency", cyc - e.c, STAGES + 1);
          @(negedge clk);
          check("pulse_width", {frame_stb, frame_err}, 0);
        end
      end
    end
  end

  logic [39:0] good;

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    sdi   = 1'b0;
    ss_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_fields", outs(), RST_F);
    check("rst_month", month, 1);
    check("rst_day", day, 1);
    check("rst_time_valid", time_valid, 0);
    check("rst_pulses", {frame_stb, frame_err}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    good = mk(8'hA5, 13, 45, 30, 11, 17, 14);
    send({24'd0, good}, 40, 1, 20);
    send({24'd0, mk(8'h5A, 13, 45, 30, 11, 17, 14)}, 40, 0, 20);
    send({24'd0, good} >> 1, 39, 0, 20);
    send({23'd0, good, 1'b1}, 41, 0, 20);
    send({24'd0, mk(8'hA5, 24, 10, 10, 5, 5, 5)}, 40, 0, 20);
    send({24'd0, mk(8'hA5, 10, 60, 10, 5, 5, 5)}, 40, 0, 20);
    send({24'd0, mk(8'hA5, 10, 10, 10, 0, 5, 5)}, 40, 0, 20);
    send({24'd0, mk(8'hA5, 23, 59, 59, 12, 31, 63)}, 40, 1, 20);
    send({24'd0, mk(8'hA5, 10, 10, 10, 13, 5, 5)}, 40, 0, 20);
    send({24'd0, mk(8'hA5, 10, 10, 10, 5, 0, 5)}, 40, 0, 20);
    send({24'd0, good} >> 20, 20, 0, 3);
    send({24'd0, mk(8'hA5, 7, 8, 9, 2, 28, 25)}, 40, 1, 20);

    // Reset mid-frame at bit 25, remaining bits must be ignored.
    good = mk(8'hA5, 9, 9, 9, 9, 9, 9);
    ss_b = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits({24'd0, good}, 39, 15);
    #3 reset = 1'b1;
    #1;
    check("midrst_fields", outs(), RST_F);
    check("midrst_time_valid", time_valid, 0);
    check("midrst_queue", q.size(), 0);
    cur_f  = RST_F;
    cur_tv = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    shift_bits({24'd0, good}, 14, 0);
    repeat (4) @(negedge clk);
    ss_b = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_hold", outs(), RST_F);
    check("post_rst_tv", time_valid, 0);
    send({24'd0, mk(8'hA5, 1, 2, 3, 4, 5, 6)}, 40, 1, 20);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
